// File: rtl/seq_pkg.sv
// Shared definitions for the programmable serial pattern detector.
// Holds FSM state encoding and default widths.
package seq_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority over increment.
// Ports: clk, rst_n, i_inc, i_clr, o_cnt[CNT_W].
module sat_counter
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector (overlap / non-overlap).
// Ports: clk, rst_n, seq_in, in_valid, cfg_load, pattern, pat_len,
//   overlap_en, clr_cnt -> d_out (1-cycle pulse), match_cnt, state_o.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             d_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_o
);

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  // Oldest history bit falls off on every shift, so only
  // PAT_W-1 bits need storing; the new bit completes the window.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  state_t           r_state;
  logic             r_dout;

  logic [LEN_W-1:0] w_len_clamp;
  logic             w_accept;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] w_fill_inc;
  logic [PAT_W-1:0] w_mask;
  logic             w_full;
  logic             w_hunt;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt;

  assign w_len_clamp = (pat_len > LEN_W'(PAT_W))
                     ? LEN_W'(PAT_W) : pat_len;

  // A load in the same cycle discards the data bit.
  assign w_accept = in_valid && !cfg_load
                 && (r_state != ST_IDLE);

  assign w_hist_nxt = {r_hist, seq_in};

  assign w_fill_inc = (r_fill == LEN_W'(PAT_W))
                    ? r_fill : r_fill + LEN_W'(1);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  // fill >= len-1, written as fill+1 >= len to avoid underflow.
  assign w_full = ({1'b0, r_fill} + (LEN_W+1)'(1))
               >= {1'b0, r_len};
  assign w_hunt = ({1'b0, w_fill_inc} + (LEN_W+1)'(1))
               >= {1'b0, r_len};

  assign w_match = w_accept && w_full
                && (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= ST_IDLE;
      r_dout  <= 1'b0;
    end else begin
      r_dout <= w_match;
      if (cfg_load) begin
        r_pat   <= pattern;
        r_len   <= w_len_clamp;
        r_ovl   <= overlap_en;
        r_hist  <= '0;
        r_fill  <= '0;
        r_state <= (w_len_clamp == '0) ? ST_IDLE : ST_FILL;
      end else if (w_accept) begin
        r_hist <= w_hist_nxt[PAT_W-2:0];
        if (w_match && !r_ovl) begin
          r_fill  <= '0;
          r_state <= ST_FILL;
        end else begin
          r_fill  <= w_fill_inc;
          r_state <= w_hunt ? ST_HUNT : ST_FILL;
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_match),
    .i_clr (clr_cnt),
    .o_cnt (w_cnt)
  );

  assign d_out     = r_dout;
  assign match_cnt = w_cnt;
  assign state_o   = r_state;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: vector table plus corner sequences.
// A second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_prog;

  logic        clk;
  logic        rst_n;
  logic        seq_in;
  logic        in_valid;
  logic        cfg_load;
  logic [7:0]  pattern;
  logic [3:0]  pat_len;
  logic        overlap_en;
  logic        clr_cnt;
  logic        d_out;
  logic [15:0] match_cnt;
  logic [1:0]  state_o;
  logic        d_out2;
  logic [1:0]  match_cnt2;
  logic [1:0]  state_o2;

  int checks = 0;
  int errors = 0;

  seq_detect_prog #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in),
    .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .d_out(d_out), .match_cnt(match_cnt),
    .state_o(state_o)
  );

  seq_detect_prog #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in),
    .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .d_out(d_out2), .match_cnt(match_cnt2),
    .state_o(state_o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [7:0]  pat;
    logic [3:0]  plen;
    logic        ovl;
    logic        v;
    logic        b;
    logic        clr;
    logic        ed;
    logic [15:0] ec;
    logic [1:0]  es;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic ld, logic [7:0] pat, logic [3:0] plen,
    logic ovl, logic v, logic b, logic clr,
    logic ed, logic [15:0] ec, logic [1:0] es);
    vec_t t;
    t.ld = ld; t.pat = pat; t.plen = plen;
    t.ovl = ovl; t.v = v; t.b = b; t.clr = clr;
    t.ed = ed; t.ec = ec; t.es = es;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drv(logic ld, logic [7:0] pat,
                     logic [3:0] plen, logic ovl,
                     logic v, logic b, logic clr);
    cfg_load   = ld;
    pattern    = pat;
    pat_len    = plen;
    overlap_en = ovl;
    in_valid   = v;
    seq_in     = b;
    clr_cnt    = clr;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pa;
  logic [3:0] s1101;

  initial begin
    rst_n = 1'b0;
    seq_in = 0; in_valid = 0; cfg_load = 0;
    pattern = '0; pat_len = '0;
    overlap_en = 0; clr_cnt = 0;

    // disabled: no load yet
    tv.push_back(mk(0,8'h00,0,0, 1,1,0, 0,0,0));
    tv.push_back(mk(0,8'h00,0,0, 1,1,0, 0,0,0));
    tv.push_back(mk(0,8'h00,0,0, 1,0,0, 0,0,0));
    tv.push_back(mk(0,8'h00,0,0, 1,1,0, 0,0,0));
    // overlap 1101: stream 1101101
    tv.push_back(mk(1,8'h0D,4,1, 0,0,0, 0,0,1));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 0,0,1));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 0,0,1));
    tv.push_back(mk(0,8'h0D,4,1, 1,0,0, 0,0,2));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 1,1,2));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 0,1,2));
    tv.push_back(mk(0,8'h0D,4,1, 1,0,0, 0,1,2));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 1,2,2));
    tv.push_back(mk(0,8'h0D,4,1, 0,0,1, 0,0,2));
    // non-overlap: stream 11011101
    tv.push_back(mk(1,8'h0D,4,0, 0,0,0, 0,0,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,0,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,0,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,0,0, 0,0,2));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 1,1,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,1,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,1,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,0,0, 0,1,2));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 1,2,1));
    // non-overlap: stream 1101101, single match
    tv.push_back(mk(1,8'h0D,4,0, 0,0,0, 0,2,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,2,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,2,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,0,0, 0,2,2));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 1,3,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,3,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,0,0, 0,3,1));
    tv.push_back(mk(0,8'h0D,4,0, 1,1,0, 0,3,2));
    // clr_cnt coincident with match
    tv.push_back(mk(1,8'h0D,4,1, 0,0,0, 0,3,1));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 0,3,1));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,0, 0,3,1));
    tv.push_back(mk(0,8'h0D,4,1, 1,0,0, 0,3,2));
    tv.push_back(mk(0,8'h0D,4,1, 1,1,1, 1,0,2));
    // len=0 disables
    tv.push_back(mk(1,8'h0D,0,1, 0,0,0, 0,0,0));
    tv.push_back(mk(0,8'h0D,0,1, 1,1,0, 0,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_state", 32'(state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drv(tv[i].ld, tv[i].pat, tv[i].plen, tv[i].ovl,
          tv[i].v, tv[i].b, tv[i].clr);
      chk($sformatf("v%0d_dout", i), 32'(d_out),
          32'(tv[i].ed));
      chk($sformatf("v%0d_cnt", i), 32'(match_cnt),
          32'(tv[i].ec));
      chk($sformatf("v%0d_state", i), 32'(state_o),
          32'(tv[i].es));
    end

    // cfg_load coincident with completing bit
    drv(1,8'h0D,4,1, 0,0,0);
    drv(0,8'h0D,4,1, 1,1,0);
    drv(0,8'h0D,4,1, 1,1,0);
    drv(0,8'h0D,4,1, 1,0,0);
    drv(1,8'h0D,4,1, 1,1,0);
    chk("coinc_dout", 32'(d_out), 0);
    chk("coinc_state", 32'(state_o), 1);
    drv(0,8'h0D,4,1, 0,0,0);
    chk("coinc_dout2", 32'(d_out), 0);
    chk("coinc_state2", 32'(state_o), 1);

    // pat_len=9 clamps to 8; valid gaps carry junk
    pa = 8'hA5;
    drv(1,8'hA5,9,1, 0,0,0);
    chk("clamp_state", 32'(state_o), 1);
    for (int i = 0; i < 8; i++) begin
      drv(0,8'hA5,9,1, 1,pa[7-i],0);
      chk($sformatf("clamp_b%0d", i), 32'(d_out),
          32'(i == 7));
      drv(0,8'hA5,9,1, 0,~pa[7-i],0);
      chk($sformatf("clamp_g%0d", i), 32'(d_out), 0);
    end

    // len=1, plus saturation on the CNT_W=2 instance
    drv(1,8'h01,1,1, 0,0,1);
    chk("l1_cnt0", 32'(match_cnt), 0);
    chk("sat_cnt0", 32'(match_cnt2), 0);
    for (int i = 1; i <= 5; i++) begin
      drv(0,8'h01,1,1, 1,1,0);
      chk($sformatf("l1_dout%0d", i), 32'(d_out), 1);
      chk($sformatf("l1_cnt%0d", i), 32'(match_cnt),
          32'(i));
      chk($sformatf("sat_dout%0d", i), 32'(d_out2), 1);
      chk($sformatf("sat_cnt%0d", i), 32'(match_cnt2),
          32'((i > 3) ? 3 : i));
    end
    drv(0,8'h01,1,1, 1,0,0);
    chk("l1_zero_dout", 32'(d_out), 0);
    chk("l1_state", 32'(state_o), 2);

    // async reset mid-stream, right after a match
    s1101 = 4'b1101;
    drv(1,8'h0D,4,1, 0,0,0);
    for (int i = 3; i >= 0; i--)
      drv(0,8'h0D,4,1, 1,s1101[i],0);
    chk("pre_rst_dout", 32'(d_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(d_out), 0);
    chk("arst_cnt", 32'(match_cnt), 0);
    chk("arst_state", 32'(state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // after reset: idle until cfg_load
    for (int i = 3; i >= 0; i--) begin
      drv(0,8'h0D,4,1, 1,s1101[i],0);
      chk($sformatf("post_rst_dout%0d", i), 32'(d_out), 0);
    end
    chk("post_rst_state", 32'(state_o), 0);
    chk("post_rst_cnt", 32'(match_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
